// File: rtl/alu_lockstep_bist.sv
// -----------------------------------------------------------------------------
// alu_lockstep_bist
//
// Built-in self-test sequencer for a dual-ALU lockstep pair. An LFSR generates
// operand/opcode vectors that drive both lanes identically. After the ALU
// pipeline delay, the sequencer samples the lanes' XOR compare outputs and
// counts mismatching vectors. It then reports pass/fail and the index of the
// first failing vector.
//
// Optional feature (macro ALU_BIST_FAULT_INJECT_EN):
//   Adds inject_en/inject_idx. When enabled, lane 2 operand A1 has bit 0
//   flipped on one chosen vector, which proves that the compare path catches a
//   real divergence. With the macro undefined, A1 always equals A0.
//
// Parameters:
//   ALU_LATENCY   clock edges from operand change to valid x/y (1..4)
//   LFSR_DEFAULT  seed used after reset and whenever the seed input is 0
//
// Ports:
//   wb_clk_i, wb_rst_i  clock, asynchronous active-high reset
//   start               run request, honoured only in IDLE or DONE
//   seed, num_vectors   run configuration, latched on an accepted start
//   inject_en/_idx      (macro only) fault-injection control, latched on start
//   A0,B0,ALU_Sel1      lane 1 operands/opcode (registered)
//   A1,B1,ALU_Sel2      lane 2 operands/opcode (registered)
//   x, y                lane compare inputs (nonzero x or y=1 means mismatch)
//   busy, done, pass    run status (pass valid while done=1)
//   err_count           mismatching vectors, saturating at 16'hFFFF
//   first_fail_idx      index of the first mismatch, 16'hFFFF if none
// -----------------------------------------------------------------------------
module alu_lockstep_bist #(
  parameter int          ALU_LATENCY  = 1,
  parameter logic [15:0] LFSR_DEFAULT = 16'hACE1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic [15:0] num_vectors,
`ifdef ALU_BIST_FAULT_INJECT_EN
  input  logic        inject_en,
  input  logic [15:0] inject_idx,
`endif
  output logic [3:0]  A0,
  output logic [3:0]  B0,
  output logic [3:0]  A1,
  output logic [3:0]  B1,
  output logic [1:0]  ALU_Sel1,
  output logic [1:0]  ALU_Sel2,
  input  logic [3:0]  x,
  input  logic        y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  // The WAIT counter runs 0..ALU_LATENCY-1, so exactly ALU_LATENCY cycles elapse.
  localparam logic [1:0]  WAIT_LAST = 2'(ALU_LATENCY - 1);
  localparam logic [15:0] NO_FAIL   = 16'hFFFF;

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [15:0] r_num;
  logic [15:0] r_idx;
  logic [1:0]  r_wait;
  logic [3:0]  r_a0, r_b0, r_a1, r_b1;
  logic [1:0]  r_sel1, r_sel2;
  logic        r_busy, r_done, r_pass;
  logic [15:0] r_err;
  logic [15:0] r_ffi;
`ifdef ALU_BIST_FAULT_INJECT_EN
  logic        r_inj_en;
  logic [15:0] r_inj_idx;
`endif

  logic [15:0] w_lfsr_next;
  logic        w_mismatch;
  logic [15:0] w_err_next;
  logic        w_last_vec;
  logic [3:0]  w_a1_flip;

  // NOTE: every signal written here receives a value first on every path, so
  // no latch is inferred even when later branches do not assign it.
  always_comb begin
    w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    w_mismatch  = (|x) | y;
    w_err_next  = r_err;
    if (w_mismatch && (r_err != 16'hFFFF)) begin
      w_err_next = r_err + 16'd1;
    end
    // The index is compared as index+1, so num_vectors=16'hFFFF ends at index
    // 16'hFFFE and the counter never needs to wrap.
    w_last_vec = ((r_idx + 16'd1) == r_num);
    w_a1_flip  = 4'b0000;
`ifdef ALU_BIST_FAULT_INJECT_EN
    if (r_inj_en && (r_idx == r_inj_idx)) begin
      w_a1_flip = 4'b0001;
    end
`endif
  end

  // NOTE: state uses non-blocking assignments so that every right-hand side
  // sees the pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_lfsr    <= LFSR_DEFAULT;
      r_num     <= '0;
      r_idx     <= '0;
      r_wait    <= '0;
      r_a0      <= '0;
      r_b0      <= '0;
      r_a1      <= '0;
      r_b1      <= '0;
      r_sel1    <= '0;
      r_sel2    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_ffi     <= NO_FAIL;
`ifdef ALU_BIST_FAULT_INJECT_EN
      r_inj_en  <= 1'b0;
      r_inj_idx <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_lfsr    <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
            r_num     <= num_vectors;
            r_idx     <= '0;
            r_err     <= '0;
            r_ffi     <= NO_FAIL;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_busy    <= 1'b1;
`ifdef ALU_BIST_FAULT_INJECT_EN
            r_inj_en  <= inject_en;
            r_inj_idx <= inject_idx;
`endif
            r_state   <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (r_num == 16'h0000) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_DRIVE;
          end
        end

        S_DRIVE: begin
          r_a0    <= r_lfsr[3:0];
          r_b0    <= r_lfsr[7:4];
          r_sel1  <= r_lfsr[9:8];
          r_a1    <= r_lfsr[3:0] ^ w_a1_flip;
          r_b1    <= r_lfsr[7:4];
          r_sel2  <= r_lfsr[9:8];
          r_lfsr  <= w_lfsr_next;
          r_wait  <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            r_state <= S_CHECK;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end

        S_CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && (r_ffi == NO_FAIL)) begin
            r_ffi <= r_idx;
          end
          r_idx <= r_idx + 16'd1;
          if (w_last_vec) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 16'h0000);
            r_state <= S_DONE;
          end else begin
            r_state <= S_DRIVE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign A0             = r_a0;
  assign B0             = r_b0;
  assign A1             = r_a1;
  assign B1             = r_b1;
  assign ALU_Sel1       = r_sel1;
  assign ALU_Sel2       = r_sel2;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign first_fail_idx = r_ffi;

endmodule

// File: tb/tb_alu_lockstep_bist.sv
// -----------------------------------------------------------------------------
// tb_alu_lockstep_bist
//
// Table-driven bench for alu_lockstep_bist. The bench plays the role of the
// ALU pair. It drives x/y per cycle, using its own knowledge of when each
// vector's CHECK cycle occurs, and compares operands against a reference LFSR.
// Hand-written sequences cover the reset, restart and continuous-mismatch cases.
// -----------------------------------------------------------------------------
module tb_alu_lockstep_bist;

  localparam int LAT = 1;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        start;
  logic [15:0] seed;
  logic [15:0] num_vectors;
  logic [3:0]  A0, B0, A1, B1;
  logic [1:0]  ALU_Sel1, ALU_Sel2;
  logic [3:0]  x;
  logic        y;
  logic        busy, done, pass;
  logic [15:0] err_count, first_fail_idx;
`ifdef ALU_BIST_FAULT_INJECT_EN
  logic        inject_en;
  logic [15:0] inject_idx;
`endif

  int total = 0;
  int bad   = 0;
  int exp_inj = -1;

  alu_lockstep_bist #(.ALU_LATENCY(LAT)) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .start          (start),
    .seed           (seed),
    .num_vectors    (num_vectors),
`ifdef ALU_BIST_FAULT_INJECT_EN
    .inject_en      (inject_en),
    .inject_idx     (inject_idx),
`endif
    .A0             (A0),
    .B0             (B0),
    .A1             (A1),
    .B1             (B1),
    .ALU_Sel1       (ALU_Sel1),
    .ALU_Sel2       (ALU_Sel2),
    .x              (x),
    .y              (y),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_idx (first_fail_idx)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [15:0] seed;
    logic [15:0] nvec;
    int          bad0;       // vector forced to mismatch, -1 for none
    int          bad1;
    bit          use_y;      // mismatch signalled on y instead of x
    bit          noise;      // x/y nonzero in every non-CHECK cycle
    bit          hold_start; // start held high for the whole run
    logic [15:0] exp_err;
    logic [15:0] exp_ffi;
    bit          exp_pass;
    int          exp_done;   // edges after the start edge until done=1
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Runs one table row from IDLE/DONE through to the expected done edge.
  task automatic run_row(input vec_t v, input string tag);
    logic [15:0] ref_l;
    logic [19:0] exp_ops;
    int lat2;
    lat2  = LAT + 2;
    ref_l = (v.seed == 16'h0000) ? 16'hACE1 : v.seed;
    seed        = v.seed;
    num_vectors = v.nvec;
    start       = 1'b1;
    x = 4'h0;
    y = 1'b0;
    tick();
    check({tag, "/busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "/done_after_start"}, 32'(done), 32'd0);
    for (int e = 1; e <= v.exp_done; e++) begin
      int  k;
      bit  is_chk;
      bit  is_bad;
      start  = v.hold_start && (e < v.exp_done);
      is_chk = ((e - 1) % lat2 == 0) && (e - 1 > 0);
      is_bad = 1'b0;
      if (is_chk) begin
        k = (e - 1) / lat2 - 1;
        is_bad = (k == v.bad0) || (k == v.bad1);
      end
      if (is_bad) begin
        x = v.use_y ? 4'b0000 : 4'b0100;
        y = v.use_y;
      end else if (v.noise && !is_chk) begin
        x = 4'hF;
        y = 1'b1;
      end else begin
        x = 4'h0;
        y = 1'b0;
      end
      tick();
      if ((e >= 2) && ((e - 2) % lat2 == 0)) begin
        k = (e - 2) / lat2;
        if (k < int'(v.nvec)) begin
          exp_ops = {ref_l[3:0], ref_l[7:4],
                     ref_l[3:0] ^ {3'b000, (k == exp_inj)}, ref_l[7:4],
                     ref_l[9:8], ref_l[9:8]};
          check($sformatf("%s/ops_v%0d", tag, k),
                32'({A0, B0, A1, B1, ALU_Sel1, ALU_Sel2}), 32'(exp_ops));
          ref_l = lfsr_step(ref_l);
        end
      end
      if (e == v.exp_done - 1) begin
        check({tag, "/done_early"}, 32'(done), 32'd0);
        check({tag, "/busy_running"}, 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    x = 4'h0;
    y = 1'b0;
    check({tag, "/done"}, 32'(done), 32'd1);
    check({tag, "/busy_done"}, 32'(busy), 32'd0);
    check({tag, "/pass"}, 32'(pass), 32'(v.exp_pass));
    check({tag, "/err_count"}, 32'(err_count), 32'(v.exp_err));
    check({tag, "/first_fail"}, 32'(first_fail_idx), 32'(v.exp_ffi));
  endtask

  initial begin
    //            seed      nvec    bad0 bad1 y  nz hs  err    ffi       pass done
    tbl[0] = '{16'h0001, 16'd100, -1, -1, 0, 0, 0, 16'd0, 16'hFFFF, 1, 301};
    tbl[1] = '{16'h0000, 16'd1,   -1, -1, 0, 0, 0, 16'd0, 16'hFFFF, 1, 4};
    tbl[2] = '{16'h1234, 16'd0,   -1, -1, 0, 0, 0, 16'd0, 16'hFFFF, 1, 1};
    tbl[3] = '{16'hBEEF, 16'd20,   5,  9, 0, 0, 1, 16'd2, 16'd5,    0, 61};
    tbl[4] = '{16'h00FF, 16'd4,    3, -1, 1, 0, 0, 16'd1, 16'd3,    0, 13};
    tbl[5] = '{16'h5A5A, 16'd6,   -1, -1, 0, 1, 0, 16'd0, 16'hFFFF, 1, 19};
    tbl[6] = '{16'h0007, 16'd3,    0,  2, 0, 0, 0, 16'd2, 16'd0,    0, 10};

    wb_rst_i    = 1'b1;
    start       = 1'b0;
    seed        = 16'h0000;
    num_vectors = 16'h0000;
    x           = 4'h0;
    y           = 1'b0;
`ifdef ALU_BIST_FAULT_INJECT_EN
    inject_en   = 1'b0;
    inject_idx  = 16'h0000;
`endif
    #1;
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/pass", 32'(pass), 32'd0);
    check("reset/err_count", 32'(err_count), 32'd0);
    check("reset/first_fail", 32'(first_fail_idx), 32'hFFFF);
    check("reset/operands", 32'({A0, B0, A1, B1, ALU_Sel1, ALU_Sel2}), 32'd0);
    #21;
    wb_rst_i = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_row(tbl[i], $sformatf("row%0d", i));
      if (i == 1) begin
        // Zero seed falls back to 16'hACE1; operands hold in DONE.
        check("row1/A0_seed0", 32'(A0), 32'h1);
        check("row1/B0_seed0", 32'(B0), 32'hE);
        check("row1/Sel_seed0", 32'(ALU_Sel1), 32'h0);
      end
    end

`ifdef ALU_BIST_FAULT_INJECT_EN
    begin
      vec_t vi;
      inject_en  = 1'b1;
      inject_idx = 16'd3;
      exp_inj    = 3;
      vi = '{16'h0010, 16'd10, 3, -1, 0, 0, 0, 16'd1, 16'd3, 0, 31};
      run_row(vi, "inject");
      inject_en = 1'b0;
      exp_inj   = -1;
    end
`endif

    // Start held through DONE restarts the run and clears the counters.
    seed        = 16'h0003;
    num_vectors = 16'd2;
    start       = 1'b1;
    tick();
    check("restart/done_cleared", 32'(done), 32'd0);
    check("restart/busy", 32'(busy), 32'd1);
    check("restart/err_cleared", 32'(err_count), 32'd0);
    check("restart/ffi_cleared", 32'(first_fail_idx), 32'hFFFF);
    repeat (7) tick();
    check("restart/done_with_start_high", 32'(done), 32'd1);
    tick();
    check("restart/second_restart", 32'(done), 32'd0);
    start = 1'b0;
    repeat (7) tick();
    check("restart/second_done", 32'(done), 32'd1);
    check("restart/second_pass", 32'(pass), 32'd1);

    // Continuous mismatch on a long run, then asynchronous reset mid-WAIT.
    seed        = 16'h0001;
    num_vectors = 16'hFFFF;
    x           = 4'hF;
    start       = 1'b1;
    tick();
    start = 1'b0;
    repeat (301) tick();
    check("long/err_count", 32'(err_count), 32'd100);
    check("long/first_fail", 32'(first_fail_idx), 32'd0);
    check("long/busy", 32'(busy), 32'd1);
    check("long/done", 32'(done), 32'd0);
    tick();
    #3;
    wb_rst_i = 1'b1;
    #1;
    check("midreset/busy", 32'(busy), 32'd0);
    check("midreset/operands", 32'({A0, B0, A1, B1, ALU_Sel1, ALU_Sel2}), 32'd0);
    check("midreset/first_fail", 32'(first_fail_idx), 32'hFFFF);
    check("midreset/err_count", 32'(err_count), 32'd0);
    @(posedge wb_clk_i);
    #3;
    wb_rst_i = 1'b0;
    x = 4'h0;
    repeat (3) tick();
    check("postreset/busy_idle", 32'(busy), 32'd0);
    check("postreset/done_idle", 32'(done), 32'd0);
    run_row(tbl[1], "postreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
